// File: rtl/secure_reg_pkg.sv
// Shared types and defaults for the secure register reader.
package secure_reg_pkg;

  localparam int DATA_W         = 8;
  localparam int ADDR_W         = 3;
  localparam int UID_W          = 3;
  localparam int DEFAULT_RD_UID = 4;

  // Reset value of every ACL entry: only DEFAULT_RD_UID may read.
  localparam logic [2**UID_W-1:0] ACL_RST_MASK = (2**UID_W)'(1) << DEFAULT_RD_UID;

  localparam logic [7:0] DENY_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_READ,
    ST_RESP
  } state_e;

endpackage

// File: rtl/secure_reg_reader_if.sv
// Request/response bus between a requester (master) and the secure reader (slave).
interface secure_reg_reader_if
  import secure_reg_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W,
  parameter int UW = UID_W
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [UW-1:0] req_uid;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport master (
    output req_valid, req_addr, req_uid, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_uid, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/secure_acl_table.sv
// Per-register access-control list with a sticky write lock.
// Lookup is combinational on the current contents, so a write landing on the
// same edge as a check never influences that check.
module secure_acl_table
  import secure_reg_pkg::*;
#(
  parameter int                   AW       = ADDR_W,
  parameter int                   UW       = UID_W,
  parameter logic [2**UW-1:0]     RST_MASK = ACL_RST_MASK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [2**UW-1:0] wr_mask,
  input  logic             lock_req,
  input  logic [AW-1:0]    lookup_addr,
  input  logic [UW-1:0]    lookup_uid,
  output logic             grant
);
  logic [2**UW-1:0] acl [2**AW];
  logic             locked;

  // ACL storage and lock bit; a write in the same cycle as the lock pulse is dropped.
  // NOTE: the table is tiny and security-relevant, so every entry is reset; a large RAM would not be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) acl[i] <= RST_MASK;
      locked <= 1'b0;
    end else begin
      if (lock_req) locked <= 1'b1;
      if (wr_en && !locked && !lock_req) acl[wr_addr] <= wr_mask;
    end
  end

  assign grant = acl[lookup_addr][lookup_uid];

endmodule

// File: rtl/secure_reg_reader.sv
// ACL-gated read front end for the protected register bank.
// Accept -> CHECK (grant lookup) -> READ (bank strobe, data capture) -> RESP.
// rsp_valid rises one cycle after entering RESP: 3 cycles after accept when
// granted, 2 when denied. Optional macro CONST_TIME_RSP_EN routes denials
// through READ too (no bank strobe, zero data) so both paths take 3 cycles.
module secure_reg_reader
  import secure_reg_pkg::*;
#(
  parameter int DW      = DATA_W,
  parameter int AW      = ADDR_W,
  parameter int UW      = UID_W,
  parameter int RD_UID  = DEFAULT_RD_UID
) (
  input  logic                clk,
  input  logic                rst,
  secure_reg_reader_if.slave  bus,
  output logic                reg_rd_en,
  output logic [AW-1:0]       reg_rd_addr,
  input  logic [DW-1:0]       reg_rd_data,
  input  logic                acl_wr_en,
  input  logic [AW-1:0]       acl_wr_addr,
  input  logic [2**UW-1:0]    acl_wr_mask,
  input  logic                acl_lock,
  output logic [7:0]          deny_cnt
);
  localparam int MW = 2**UW;

  state_e        state;
  logic [AW-1:0] lat_addr;
  logic [UW-1:0] lat_uid;
  logic          granted;
  logic          grant;

  secure_acl_table #(
    .AW       (AW),
    .UW       (UW),
    .RST_MASK (MW'(1) << RD_UID)
  ) u_acl (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (acl_wr_en),
    .wr_addr     (acl_wr_addr),
    .wr_mask     (acl_wr_mask),
    .lock_req    (acl_lock),
    .lookup_addr (lat_addr),
    .lookup_uid  (lat_uid),
    .grant       (grant)
  );

  // Request FSM with registered handshake, bank strobe, response and deny counter.
  // NOTE: non-blocking assignments throughout so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      lat_addr      <= '0;
      lat_uid       <= '0;
      granted       <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      reg_rd_en     <= 1'b0;
      reg_rd_addr   <= '0;
      deny_cnt      <= '0;
    end else begin
      reg_rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            lat_addr      <= bus.req_addr;
            lat_uid       <= bus.req_uid;
            bus.req_ready <= 1'b0;
            state         <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          granted <= grant;
          if (grant) begin
            reg_rd_en   <= 1'b1;
            reg_rd_addr <= lat_addr;
            state       <= ST_READ;
          end else begin
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b1;
            if (deny_cnt != DENY_MAX) deny_cnt <= deny_cnt + 8'd1;
`ifdef CONST_TIME_RSP_EN
            state <= ST_READ;
`else
            state <= ST_RESP;
`endif
          end
        end
        ST_READ: begin
          if (granted) begin
            bus.rsp_data <= reg_rd_data;
            bus.rsp_err  <= 1'b0;
          end else begin
            bus.rsp_data <= '0;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (!bus.rsp_valid) begin
            bus.rsp_valid <= 1'b1;
          end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secure_reg_reader.sv
// Self-checking bench for secure_reg_reader: directed table, multi-cycle
// corner sequences, then randomized traffic against an ACL/deny-count model.
module tb_secure_reg_reader;
  import secure_reg_pkg::*;

`ifdef CONST_TIME_RSP_EN
  localparam int DENY_LAT = 3;
`else
  localparam int DENY_LAT = 2;
`endif
  localparam int GRANT_LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reg_rd_en;
  logic [2:0] reg_rd_addr;
  logic [7:0] reg_rd_data;
  logic       acl_wr_en = 1'b0;
  logic [2:0] acl_wr_addr = '0;
  logic [7:0] acl_wr_mask = '0;
  logic       acl_lock = 1'b0;
  logic [7:0] deny_cnt;

  secure_reg_reader_if bus ();

  secure_reg_reader dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .reg_rd_en   (reg_rd_en),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data),
    .acl_wr_en   (acl_wr_en),
    .acl_wr_addr (acl_wr_addr),
    .acl_wr_mask (acl_wr_mask),
    .acl_lock    (acl_lock),
    .deny_cnt    (deny_cnt)
  );

  always #5 clk = ~clk;

  // Bank: a strobe issued at one edge is answered in time for the next edge;
  // junk is shown whenever no strobe is active.
  logic [7:0] bank [8];
  assign reg_rd_data = reg_rd_en ? bank[reg_rd_addr] : 8'hEE;

  // Reference model: ACL contents, lock bit, deny count.
  logic [7:0] acl_m [8];
  logic       lock_m;
  int         deny_m;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) acl_m[i] = 8'h10;
    lock_m = 1'b0;
    deny_m = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One ACL-port cycle; the model applies the same write/lock rules.
  task automatic acl_op(input logic en, input logic [2:0] a, input logic [7:0] m, input logic lk);
    acl_wr_en = en; acl_wr_addr = a; acl_wr_mask = m; acl_lock = lk;
    if (en && !lock_m && !lk) acl_m[a] = m;
    if (lk) lock_m = 1'b1;
    @(posedge clk); #1;
    acl_wr_en = 1'b0; acl_lock = 1'b0;
  endtask

  // Called just after the accept edge; waits (bounded) for rsp_valid.
  task automatic wait_valid(input logic [2:0] a, output int lat, output int rd_cnt, output logic rd_ok);
    lat = -1; rd_cnt = 0; rd_ok = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      acl_wr_en = 1'b0;
      if (reg_rd_en) begin
        rd_cnt++;
        if (k != 1 || reg_rd_addr != a) rd_ok = 1'b0;
      end
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // Full read with rsp_ready held high; optional ACL write during the CHECK cycle.
  task automatic run_read(input logic [2:0] a, input logic [2:0] u, input logic cw, input logic [7:0] cm,
                          output int lat, output logic [7:0] data, output logic err, output int rd_cnt,
                          output logic rd_ok, output logic ready_ok, output logic clear_ok);
    ready_ok = bus.req_ready;
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_uid = u;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (cw) begin
      acl_wr_en = 1'b1; acl_wr_addr = a; acl_wr_mask = cm;
    end
    wait_valid(a, lat, rd_cnt, rd_ok);
    data = bus.rsp_data;
    err  = bus.rsp_err;
    clear_ok = 1'b0;
    if (lat > 0) begin
      @(posedge clk); #1;
      clear_ok = !bus.rsp_valid && !bus.rsp_err && bus.rsp_data == 8'h00 && bus.req_ready;
    end
  endtask

  task automatic model_read(input logic [2:0] a, input logic [2:0] u, input logic cw, input logic [7:0] cm,
                            input string tag);
    logic g;
    int lat, rd_cnt;
    logic [7:0] data;
    logic err, rd_ok, ready_ok, clear_ok;
    g = acl_m[a][u];
    if (cw && !lock_m) acl_m[a] = cm;
    if (!g && deny_m < 255) deny_m++;
    run_read(a, u, cw, cm, lat, data, err, rd_cnt, rd_ok, ready_ok, clear_ok);
    check({tag, "_ready"}, ready_ok, 1);
    check({tag, "_lat"}, lat, g ? GRANT_LAT : DENY_LAT);
    check({tag, "_data"}, data, g ? bank[a] : 8'h00);
    check({tag, "_err"}, err, !g);
    check({tag, "_rd_en_cnt"}, rd_cnt, g ? 1 : 0);
    check({tag, "_rd_en_timing"}, rd_ok, 1);
    check({tag, "_deny_cnt"}, deny_cnt, deny_m);
    check({tag, "_cleared"}, clear_ok, 1);
  endtask

  typedef struct {
    logic [2:0] addr;
    logic [2:0] uid;
    logic       exp_err;
    logic [7:0] exp_data;
    logic [7:0] exp_deny;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, rd_cnt, valid_seen;
    logic [7:0] data;
    logic err, rd_ok, ready_ok, clear_ok, g1, g2;

    vecs[0] = '{3'd2, 3'd4, 1'b0, 8'hA5, 8'd0};
    vecs[1] = '{3'd2, 3'd1, 1'b1, 8'h00, 8'd1};
    vecs[2] = '{3'd0, 3'd4, 1'b0, 8'hA0, 8'd1};
    vecs[3] = '{3'd7, 3'd4, 1'b0, 8'hA7, 8'd1};
    vecs[4] = '{3'd7, 3'd0, 1'b1, 8'h00, 8'd2};
    vecs[5] = '{3'd5, 3'd7, 1'b1, 8'h00, 8'd3};
    vecs[6] = '{3'd4, 3'd4, 1'b0, 8'hA4, 8'd3};

    for (int i = 0; i < 8; i++) bank[i] = 8'hA0 + 8'(i);
    bank[2] = 8'hA5;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_uid = '0; bus.rsp_ready = 1'b1;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rd_en", reg_rd_en, 0);
    check("rst_rd_addr", reg_rd_addr, 0);
    check("rst_deny_cnt", deny_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table against default ACL.
    for (int i = 0; i < 7; i++) begin
      run_read(vecs[i].addr, vecs[i].uid, 1'b0, 8'h00, lat, data, err, rd_cnt, rd_ok, ready_ok, clear_ok);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_err ? DENY_LAT : GRANT_LAT);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d_rd_en", i), rd_cnt, vecs[i].exp_err ? 0 : 1);
      check($sformatf("vec%0d_rd_timing", i), rd_ok, 1);
      check($sformatf("vec%0d_deny", i), deny_cnt, vecs[i].exp_deny);
      check($sformatf("vec%0d_cleared", i), clear_ok, 1);
    end
    deny_m = 3;

    // ACL write, write during CHECK uses old value, lock behaviour.
    acl_op(1'b1, 3'd2, 8'h02, 1'b0);
    model_read(3'd2, 3'd1, 1'b0, 8'h00, "acl_wr_grant");
    model_read(3'd5, 3'd4, 1'b1, 8'h00, "wr_in_check_old");
    model_read(3'd5, 3'd4, 1'b0, 8'h00, "wr_in_check_new");
    acl_op(1'b1, 3'd2, 8'h00, 1'b1);
    model_read(3'd2, 3'd1, 1'b0, 8'h00, "lock_same_cycle");
    acl_op(1'b1, 3'd2, 8'h00, 1'b0);
    model_read(3'd2, 3'd1, 1'b0, 8'h00, "locked_write_ignored");

    // Backpressure: response held, second request waits until after handshake.
    g1 = acl_m[2][1];
    g2 = acl_m[3][4];
    if (!g1) deny_m++;
    if (!g2) deny_m++;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 3'd2; bus.req_uid = 3'd1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_valid(3'd2, lat, rd_cnt, rd_ok);
    check("bp_lat", lat, g1 ? GRANT_LAT : DENY_LAT);
    bus.req_valid = 1'b1; bus.req_addr = 3'd3; bus.req_uid = 3'd4;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", c), bus.rsp_valid, 1);
      check($sformatf("bp_hold%0d_data", c), bus.rsp_data, g1 ? bank[2] : 8'h00);
      check($sformatf("bp_hold%0d_err", c), bus.rsp_err, !g1);
      check($sformatf("bp_hold%0d_req_ready", c), bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_valid", bus.rsp_valid, 0);
    check("bp_hs_data", bus.rsp_data, 0);
    check("bp_hs_err", bus.rsp_err, 0);
    check("bp_hs_req_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    check("bp_second_accepted", bus.req_ready, 0);
    bus.req_valid = 1'b0;
    wait_valid(3'd3, lat, rd_cnt, rd_ok);
    check("bp2_lat", lat, g2 ? GRANT_LAT : DENY_LAT);
    check("bp2_data", bus.rsp_data, g2 ? bank[3] : 8'h00);
    check("bp2_err", bus.rsp_err, !g2);
    check("bp2_deny_cnt", deny_cnt, deny_m);
    @(posedge clk); #1;
    check("bp2_cleared", bus.rsp_valid, 0);

    // Asynchronous reset while in READ.
    bus.req_valid = 1'b1; bus.req_addr = 3'd3; bus.req_uid = 3'd4;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_rd_en", reg_rd_en, 1);
    rst = 1'b1;
    #1;
    check("arst_rsp_valid", bus.rsp_valid, 0);
    check("arst_rsp_err", bus.rsp_err, 0);
    check("arst_rsp_data", bus.rsp_data, 0);
    check("arst_rd_en", reg_rd_en, 0);
    check("arst_rd_addr", reg_rd_addr, 0);
    check("arst_deny_cnt", deny_cnt, 0);
    check("arst_req_ready", bus.req_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    valid_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid || reg_rd_en) valid_seen++;
    end
    check("arst_no_response", valid_seen, 0);
    model_read(3'd2, 3'd1, 1'b0, 8'h00, "arst_acl_deny");
    model_read(3'd2, 3'd4, 1'b0, 8'h00, "arst_acl_grant");
    acl_op(1'b1, 3'd2, 8'h02, 1'b0);
    model_read(3'd2, 3'd1, 1'b0, 8'h00, "arst_unlocked");

    // Randomized traffic against the model.
    for (int i = 0; i < 120; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3)
        acl_op(1'b1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'b0);
      else if (r == 3 && i > 90)
        acl_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'b1);
      else
        model_read(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 4) == 0, 8'($urandom_range(0, 255)), $sformatf("rnd%0d", i));
    end

    // Deny counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) model_read(3'd0, 3'd0, 1'b0, 8'h00, $sformatf("sat%0d", i));
    check("deny_saturated", deny_cnt, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
